qspi_read_ctrl: RTL and testbench
=================================

# qspi_read_ctrl

Sequencer that turns cache line-fill requests into complete QSPI read bursts. It loads the command and line-aligned address into the QSPI reader (cmd/addr shifter) and waits for the reader's `done`. It then samples nibbles from the flash data pins and packs them into 32-bit words, delivering them to the cache over a valid/ready stream. It sits between the cache miss logic and the QSPI reader/pad ring, and owns chip-select, SCLK gating and pad direction.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per burst; power of two, 1..16.
- `READ_CMD`, default 8'h3B: command byte loaded into the reader.
- `CS_GAP`, default 2: minimum cycles `cs_n` stays high between bursts; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  fill request.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_addr`  in  32  byte address; low log2(LINE_WORDS*4) bits ignored.
- `rd_valid`  out  1  `rd_data` valid.
- `rd_ready`  in  1  consumer accepts word.
- `rd_data`  out  32  assembled word.
- `rd_last`  out  1  qualifies the final word of the burst.
- `busy`  out  1  high in every state except IDLE.
- `rdr_cmd`  out  8  command to reader (`READ_CMD`, constant).
- `rdr_addr`  out  32  line-aligned address to reader.
- `rdr_we`  out  8  reader load strobe; 8'hFF for one cycle, else 8'h00.
- `rdr_done`  in  1  reader finished cmd/addr/dummy phases.
- `cs_n`  out  1  flash chip select, active low.
- `sclk_en`  out  1  flash clock gate enable.
- `io_oe`  out  1  pad output enable for io[3:0].
- `io_in`  in  4  flash data pins.

## Operation
- States: IDLE, LOAD, CMD_ADDR, DATA, GAP.
- IDLE: `req_ready`=1. On handshake, register `rdr_addr` = {req_addr[31:L], L'b0}, with L = log2(LINE_WORDS*4). Go to LOAD.
- LOAD: one cycle. `rdr_we`=8'hFF, `cs_n`=0, `sclk_en`=0, `io_oe`=1. Go to CMD_ADDR.
- CMD_ADDR: `cs_n`=0, `sclk_en`=1, `io_oe`=1. Stay until `rdr_done`=1 is sampled, then go to DATA.
- DATA: `cs_n`=0, `io_oe`=0. Capture `io_in` on each cycle with `cap` = 1, where `cap` = !(nib_cnt==7 && out_full && !rd_ready). `sclk_en` = `cap`, so the flash clock stalls under backpressure.
- Nibble order: the high nibble of each byte comes first. The first byte of each word lands in rd_data[7:0] (little-endian byte packing).
- When the 8th nibble is captured, load the word into the output register: `rd_valid`=1, and `rd_last`=1 if it is word LINE_WORDS-1. `nib_cnt` wraps to 0.
- A word that completes while the register drains in the same cycle replaces it; no bubble.
- After the last word is captured, go to GAP. The last word may still be pending in the output register.
- GAP: `cs_n`=1, `sclk_en`=0. Hold CS_GAP cycles, then go to IDLE once the output register is empty.
- `req_valid` outside IDLE is ignored; the request is not queued.
- Counters: `nib_cnt` is 3 bits; `word_cnt` is log2(LINE_WORDS)+1 bits and never wraps within a burst.

## Timing
- Reset (async, immediate): state IDLE, `req_ready`=1, `busy`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0, `rdr_we`=0, `rdr_addr`=0, `cs_n`=1, `sclk_en`=0, `io_oe`=0.
- Reset mid-burst aborts: `cs_n` rises asynchronously and any pending word is dropped.
- Handshake at cycle 0; `rdr_we` at cycle 1; CMD_ADDR from cycle 2.
- First DATA capture occurs the cycle after `rdr_done` is sampled high.
- Without backpressure, word k is valid 8(k+1) cycles after DATA entry. A burst takes 8·LINE_WORDS DATA cycles.
- Minimum request-to-request spacing: CS_GAP cycles of `cs_n` high, plus one IDLE cycle.
- `rd_valid` holds, with `rd_data`/`rd_last` stable, until `rd_ready`.
- `rdr_done` is ignored outside CMD_ADDR.

## Test plan
- req_addr=0x0000_1234, LINE_WORDS=4, `rdr_done` 10 cycles after LOAD, io_in nibbles 0,1,2,…,F repeating -> `rdr_addr`=0x0000_1230. Words: 0x67452301, 0xEFCDAB89, 0x67452301, 0xEFCDAB89; `rd_last` only on the 4th word.
- Same stimulus with `rd_ready`=0 for 20 cycles from the first `rd_valid` -> `sclk_en`=0 during the stall with `nib_cnt`=7, no nibble lost, identical word sequence.
- Two back-to-back requests (0x100, then 0x200 held valid) -> second `rdr_we` occurs ≥CS_GAP+1 cycles after `cs_n` rises. `req_ready`=0 throughout the first burst.
- `rst` pulsed mid-DATA after word 1 -> `cs_n`=1, `rd_valid`=0 asynchronously. A new request afterwards completes normally with correct words.
- `rdr_done` held high during LOAD and GAP -> no effect. Transition occurs only when sampled in CMD_ADDR.
- LINE_WORDS=1 -> single word, with `rd_valid` and `rd_last` asserted together.

Source files
------------

// File: rtl/qspi_read_ctrl.sv
// -----------------------------------------------------------------------------
// qspi_read_ctrl
//
// Turns cache line-fill requests into complete QSPI read bursts. A request is
// accepted in IDLE, the line-aligned address and the read command are loaded
// into the external cmd/addr shifter, and once that shifter reports done the
// flash data pins are sampled a nibble per cycle and packed into 32-bit words
// that are streamed to the cache. The block owns chip-select, the SCLK gate
// and the pad direction for io[3:0].
//
// Parameters
//   LINE_WORDS : 32-bit words per burst (power of two, 1..16)
//   READ_CMD   : command byte presented to the reader
//   CS_GAP     : minimum cycles cs_n stays high between bursts (>= 1)
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid/req_ready  : fill request handshake, req_addr = byte address
//   rd_valid/rd_ready    : word stream to the cache, rd_data, rd_last
//   busy                 : high whenever the sequencer is not idle
//   rdr_cmd, rdr_addr    : command and line-aligned address for the reader
//   rdr_we               : reader load strobe (8'hFF for one cycle)
//   rdr_done             : reader finished cmd/addr/dummy phases
//   cs_n, sclk_en, io_oe : flash chip select, clock gate, pad output enable
//   io_in                : flash data pins
// -----------------------------------------------------------------------------
module qspi_read_ctrl #(
    parameter int         LINE_WORDS = 4,
    parameter logic [7:0] READ_CMD   = 8'h3B,
    parameter int         CS_GAP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        busy,
    output logic [7:0]  rdr_cmd,
    output logic [31:0] rdr_addr,
    output logic [7:0]  rdr_we,
    input  logic        rdr_done,
    output logic        cs_n,
    output logic        sclk_en,
    output logic        io_oe,
    input  logic [3:0]  io_in
);

    localparam int               LINE_BYTES = LINE_WORDS * 4;
    localparam int               WC_W       = $clog2(LINE_WORDS) + 1;
    localparam int               GC_W       = $clog2(CS_GAP + 1);
    localparam logic [31:0]      ADDR_MASK  = ~(32'(LINE_BYTES) - 32'd1);
    localparam logic [WC_W-1:0]  LAST_WORD  = WC_W'(LINE_WORDS - 1);
    localparam logic [GC_W-1:0]  GAP_LAST   = GC_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMD_ADDR,
        S_DATA,
        S_GAP
    } state_t;

    state_t            state_reg;
    logic [2:0]        nib_cnt_reg;
    logic [WC_W-1:0]   word_cnt_reg;
    logic [GC_W-1:0]   gap_cnt_reg;
    logic [31:0]       shift_reg;
    logic [31:0]       rd_data_reg;
    logic              rd_valid_reg;
    logic              rd_last_reg;
    logic [31:0]       rdr_addr_reg;
    logic [7:0]        rdr_we_reg;
    logic              req_ready_reg;
    logic              busy_reg;
    logic              cs_n_reg;
    logic              io_oe_reg;
    logic              sclk_cmd_reg;   // clock runs freely during cmd/addr

    logic              cap;
    logic              capture;
    logic [31:0]       word_next;
    logic [4:0]        nib_pos;

    // Only the 8th nibble can be blocked: it needs the output register, and
    // that register is still holding an unaccepted word.
    assign cap     = !(nib_cnt_reg == 3'd7 && rd_valid_reg && !rd_ready);
    assign capture = (state_reg == S_DATA) && cap;

    // Within a byte the high nibble arrives first; bytes fill the word
    // little-endian, so nibble n lands at byte n/2, upper half when n is even.
    assign nib_pos = {nib_cnt_reg[2:1], ~nib_cnt_reg[0], 2'b00};

    always_comb begin
        word_next               = shift_reg;
        word_next[nib_pos +: 4] = io_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            nib_cnt_reg   <= 3'd0;
            word_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            shift_reg     <= 32'd0;
            rd_data_reg   <= 32'd0;
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
            rdr_addr_reg  <= 32'd0;
            rdr_we_reg    <= 8'h00;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            cs_n_reg      <= 1'b1;
            io_oe_reg     <= 1'b0;
            sclk_cmd_reg  <= 1'b0;
        end else begin
            // Drain first; a word completing in the same cycle overrides this
            // so back-to-back words leave no bubble.
            if (rd_valid_reg && rd_ready) begin
                rd_valid_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        state_reg     <= S_LOAD;
                        rdr_addr_reg  <= req_addr & ADDR_MASK;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        rdr_we_reg    <= 8'hFF;
                        cs_n_reg      <= 1'b0;
                        io_oe_reg     <= 1'b1;
                    end
                end

                S_LOAD: begin
                    state_reg    <= S_CMD_ADDR;
                    rdr_we_reg   <= 8'h00;
                    sclk_cmd_reg <= 1'b1;
                end

                S_CMD_ADDR: begin
                    if (rdr_done) begin
                        state_reg    <= S_DATA;
                        io_oe_reg    <= 1'b0;
                        sclk_cmd_reg <= 1'b0;
                        nib_cnt_reg  <= 3'd0;
                        word_cnt_reg <= '0;
                    end
                end

                S_DATA: begin
                    if (cap) begin
                        shift_reg   <= word_next;
                        nib_cnt_reg <= nib_cnt_reg + 3'd1;
                        if (nib_cnt_reg == 3'd7) begin
                            rd_data_reg  <= word_next;
                            rd_valid_reg <= 1'b1;
                            rd_last_reg  <= (word_cnt_reg == LAST_WORD);
                            word_cnt_reg <= word_cnt_reg + WC_W'(1);
                            if (word_cnt_reg == LAST_WORD) begin
                                // Last word may still sit in the output
                                // register; GAP waits for it to drain.
                                state_reg   <= S_GAP;
                                cs_n_reg    <= 1'b1;
                                gap_cnt_reg <= '0;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt_reg != GAP_LAST) begin
                        gap_cnt_reg <= gap_cnt_reg + GC_W'(1);
                    end else if (!rd_valid_reg) begin
                        state_reg     <= S_IDLE;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end

                default: begin
                    state_reg     <= S_IDLE;
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    cs_n_reg      <= 1'b1;
                    io_oe_reg     <= 1'b0;
                    sclk_cmd_reg  <= 1'b0;
                    rdr_we_reg    <= 8'h00;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign busy      = busy_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;
    assign rd_last   = rd_last_reg;
    assign rdr_cmd   = READ_CMD;
    assign rdr_addr  = rdr_addr_reg;
    assign rdr_we    = rdr_we_reg;
    assign cs_n      = cs_n_reg;
    assign io_oe     = io_oe_reg;
    // In DATA the flash clock follows cap so a stalled nibble is not lost.
    assign sclk_en   = sclk_cmd_reg | capture;

endmodule

// File: tb/tb_qspi_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qspi_read_ctrl
//
// Drives qspi_read_ctrl (LINE_WORDS=4) and a second instance with
// LINE_WORDS=1 from a simple flash model: a nibble stream that advances one
// nibble per data-phase SCLK pulse. Expected words are packed from that stream
// (high nibble first within a byte, bytes little-endian within the word).
// -----------------------------------------------------------------------------
module tb_qspi_read_ctrl;

    localparam int LW     = 4;
    localparam int CS_GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_ready = 1'b0;
    logic        rdr_done = 1'b0;
    logic [3:0]  io_in;

    logic        req_valid = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic        req_ready, rd_valid, rd_last, busy, cs_n, sclk_en, io_oe;
    logic [31:0] rd_data, rdr_addr;
    logic [7:0]  rdr_cmd, rdr_we;

    logic        b_req_valid = 1'b0;
    logic [31:0] b_req_addr  = 32'd0;
    logic        b_req_ready, b_rd_valid, b_rd_last, b_busy, b_cs_n, b_sclk_en, b_io_oe;
    logic [31:0] b_rd_data, b_rdr_addr;
    logic [7:0]  b_rdr_cmd, b_rdr_we;

    qspi_read_ctrl #(.LINE_WORDS(LW), .READ_CMD(8'h3B), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .busy(busy), .rdr_cmd(rdr_cmd),
        .rdr_addr(rdr_addr), .rdr_we(rdr_we), .rdr_done(rdr_done), .cs_n(cs_n),
        .sclk_en(sclk_en), .io_oe(io_oe), .io_in(io_in)
    );

    qspi_read_ctrl #(.LINE_WORDS(1), .READ_CMD(8'h3B), .CS_GAP(CS_GAP)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .rd_valid(b_rd_valid), .rd_ready(rd_ready),
        .rd_data(b_rd_data), .rd_last(b_rd_last), .busy(b_busy), .rdr_cmd(b_rdr_cmd),
        .rdr_addr(b_rdr_addr), .rdr_we(b_rdr_we), .rdr_done(rdr_done), .cs_n(b_cs_n),
        .sclk_en(b_sclk_en), .io_oe(b_io_oe), .io_in(io_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Flash model: nibble stream plus read pointer advanced on data-phase SCLK.
    logic [3:0] stream [1024];
    logic [9:0] fl_idx = 10'd0;
    bit         flash_adv = 1'b0;
    int         cs_rise_cyc = 0;
    logic       cs_prev = 1'b1;

    assign io_in = stream[fl_idx];

    always @(negedge clk) begin
        flash_adv = (!cs_n && sclk_en && !io_oe) || (!b_cs_n && b_sclk_en && !b_io_oe);
        if (cs_n && !cs_prev) cs_rise_cyc = cyc;
        cs_prev = cs_n;
    end

    always @(posedge clk) begin
        #2;
        if (flash_adv) fl_idx = fl_idx + 10'd1;
    end

    function automatic logic [31:0] exp_word(input int base, input int k);
        logic [31:0] w;
        w = 32'd0;
        for (int b = 0; b < 4; b++) begin
            w[8*b +: 8] = {stream[(base + 8*k + 2*b) % 1024],
                           stream[(base + 8*k + 2*b + 1) % 1024]};
        end
        return w;
    endfunction

    // mode: 0 = always ready, 1 = 20-cycle stall from first rd_valid, 2 = random ready
    task automatic run_burst(input logic [31:0] addr, input int done_dly, input int mode,
                             input bit directed, input bit done_noise, input bit pre_issued,
                             input bit hold_next, input logic [31:0] next_addr,
                             input int abort_after);
        int base, done_c, k, guard, stall_n;
        bit seen_v, held_v, rr_seen, ok;
        logic [31:0] held_d;
        logic held_l;
        base = int'(fl_idx);
        for (int j = 0; j < 8*LW; j++)
            stream[(base + j) % 1024] = directed ? 4'(j % 16) : 4'($urandom_range(0, 15));
        rd_ready = (mode != 1);

        if (!pre_issued) begin
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = req_ready; end
            chk("idle_wait", 64'(ok), 1);
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_addr  = addr;
            @(posedge clk); #1;
            if (hold_next) req_addr = next_addr;
            else req_valid = 1'b0;
        end else begin
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin @(posedge clk); #1; ok = (rdr_we == 8'hFF); end
            chk("we_wait", 64'(ok), 1);
            req_valid = 1'b0;
            chk("cs_gap", 64'((cyc - cs_rise_cyc) >= CS_GAP + 1), 1);
        end

        // LOAD cycle
        chk("load_we", rdr_we, 8'hFF);
        chk("load_addr", rdr_addr, addr & ~32'(LW*4 - 1));
        chk("load_pins", {cs_n, sclk_en, io_oe, busy, req_ready}, 5'b00110);
        chk("cmd", rdr_cmd, 8'h3B);
        rdr_done = done_noise;

        for (int c = 2; c <= 1 + done_dly; c++) begin
            @(posedge clk); #1;
            rdr_done = (c == 1 + done_dly);
            if (c == 2) chk("cmd_pins", {cs_n, sclk_en, io_oe, rdr_we}, {3'b011, 8'h00});
        end
        done_c = cyc;

        k = 0; seen_v = 0; held_v = 0; rr_seen = 0; stall_n = 0; guard = 0;
        held_d = 32'd0; held_l = 1'b0;
        while (k < LW && guard < 3000) begin
            @(posedge clk); #1;
            rdr_done = done_noise;
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (stall_n >= 20);
                default: rd_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            guard++;
            if (guard == 1) chk("data_pins", {cs_n, io_oe}, 2'b00);
            rr_seen |= req_ready;
            if (held_v) chk("hold", {rd_valid, rd_last, rd_data}, {1'b1, held_l, held_d});
            if (rd_valid && !seen_v) begin
                seen_v = 1'b1;
                chk("first_lat", 64'(cyc - done_c), 9);
            end
            if (seen_v && mode == 1) begin
                stall_n++;
                if (stall_n == 20) chk("stall_sclk", sclk_en, 0);
            end
            if (rd_valid && rd_ready) begin
                chk("word", rd_data, exp_word(base, k));
                chk("last", rd_last, 64'(k == LW - 1));
                $display("txn addr %08h word %0d data %08h last %0b", addr, k, rd_data, rd_last);
                k++;
                held_v = 1'b0;
            end else begin
                held_v = rd_valid;
                held_d = rd_data;
                held_l = rd_last;
            end
            if (abort_after >= 0 && k == abort_after + 1) begin
                @(posedge clk); #1;
                rst = 1'b1;
                #1;
                chk("abort_pins", {cs_n, rd_valid, busy, sclk_en, io_oe}, 5'b10000);
                chk("abort_data", rd_data, 0);
                #1;
                rst = 1'b0;
                rd_ready = 1'b0;
                rdr_done = 1'b0;
                $display("txn addr %08h aborted by reset after word %0d", addr, abort_after);
                return;
            end
        end
        chk("burst_words", 64'(k), 64'(LW));

        if (!hold_next) begin
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(posedge clk); #1;
                rdr_done = done_noise;
                rd_ready = 1'b1;
                @(negedge clk);
                ok = !busy;
            end
            chk("to_idle", 64'(ok), 1);
            chk("idle_pins", {req_ready, cs_n, sclk_en, io_oe, rd_valid}, 5'b11000);
            rdr_done = 1'b0;
        end else begin
            chk("req_ready_busy", 64'(rr_seen), 0);
        end
    endtask

    task automatic run_b(input logic [31:0] addr);
        int base;
        bit ok;
        base = int'(fl_idx);
        for (int j = 0; j < 8; j++) stream[(base + j) % 1024] = 4'($urandom_range(0, 15));
        rd_ready = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b1;
        b_req_addr  = addr;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #1; ok = (b_rdr_we == 8'hFF); end
        b_req_valid = 1'b0;
        chk("b_we", 64'(ok), 1);
        chk("b_addr", b_rdr_addr, addr & ~32'h3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdr_done = 1'b1;
        @(posedge clk); #1;
        rdr_done = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = b_rd_valid; end
        chk("b_valid_last", {b_rd_valid, b_rd_last}, 2'b11);
        chk("b_word", b_rd_data, exp_word(base, 0));
        $display("txn b addr %08h word 0 data %08h last %0b", addr, b_rd_data, b_rd_last);
        @(negedge clk);
        chk("b_single", b_rd_valid, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = !b_busy; end
        chk("b_idle", 64'(ok), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) stream[i] = 4'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_pins", {req_ready, busy, rd_valid, rd_last, cs_n, sclk_en, io_oe}, 7'b1000100);
        chk("rst_data", rd_data, 0);
        chk("rst_addr", rdr_addr, 0);
        chk("rst_we", rdr_we, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed: nibbles 0..F, done 10 cycles after LOAD, no backpressure
        run_burst(32'h0000_1234, 10, 0, 1, 0, 0, 0, 32'd0, -1);
        // Same stimulus with a 20-cycle stall from the first rd_valid
        run_burst(32'h0000_1234, 10, 1, 1, 0, 0, 0, 32'd0, -1);
        // Back-to-back: second request held valid through the first burst
        run_burst(32'h0000_0100, 5, 0, 0, 0, 0, 1, 32'h0000_0200, -1);
        run_burst(32'h0000_0200, 4, 0, 0, 0, 1, 0, 32'd0, -1);
        // Reset mid-DATA after word 1, then a clean burst
        run_burst(32'h0000_4440, 3, 0, 0, 0, 0, 0, 32'd0, 1);
        run_burst(32'h0000_5678, 6, 2, 0, 0, 0, 0, 32'd0, -1);
        // rdr_done held high in LOAD, DATA and GAP
        run_burst(32'h0000_9ABC, 7, 0, 0, 1, 0, 0, 32'd0, -1);
        // Randomized bursts
        for (int n = 0; n < 8; n++)
            run_burst($urandom, $urandom_range(1, 15), 2, 0, 0, 0, 0, 32'd0, -1);
        // LINE_WORDS = 1 instance
        run_b(32'hDEAD_BEEF);
        run_b($urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
